// File: rtl/clink_frame_monitor.sv
// -----------------------------------------------------------------------------
// clink_frame_monitor
//
// Passive Camera Link frame monitor. Forwards fval/lval/data through a single
// register stage and measures the frame structure seen on the way through:
// pixels per line, lines per frame, peak pixel value and in-frame line gaps.
// Status is published once per closed line or frame. Sticky error flags flag
// anything that does not match the expected geometry.
//
// Parameters
//   LINE_WIDTH      expected pixels per line
//   FRAME_LINES     expected lines per frame
//   TIMEOUT_TICKS   longest tolerated in-frame gap between lines, in cycles
//
// Ports
//   clink_out_clk     clock, rising edge
//   rst               synchronous, active-high reset
//   in_fval/in_lval   frame/line valid from the upstream rate converter
//   in_data           pixel data, valid while in_lval=1
//   stat_clr          one-cycle pulse, clears frame_cnt and the err_* flags
//   out_fval/lval/data  inputs delayed by one cycle
//   frame_done        one-cycle pulse when a frame closes
//   frame_cnt         completed frames, wraps
//   last_line_len     pixel count of the most recently closed line
//   last_frame_lines  line count of the most recently closed frame
//   last_frame_max    peak pixel value of the most recently closed frame
//   err_line_len      sticky: a line closed with the wrong pixel count
//   err_frame_lines   sticky: a frame closed with the wrong line count
//   err_lval_nofval   sticky: lval seen outside fval
//   err_timeout       sticky: an in-frame line gap reached TIMEOUT_TICKS
// -----------------------------------------------------------------------------
module clink_frame_monitor #(
    parameter int unsigned LINE_WIDTH    = 640,
    parameter int unsigned FRAME_LINES   = 512,
    parameter int unsigned TIMEOUT_TICKS = 4000
) (
    input  logic        clink_out_clk,
    input  logic        rst,
    input  logic        in_fval,
    input  logic        in_lval,
    input  logic [15:0] in_data,
    input  logic        stat_clr,
    output logic        out_fval,
    output logic        out_lval,
    output logic [15:0] out_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [15:0] last_line_len,
    output logic [15:0] last_frame_lines,
    output logic [15:0] last_frame_max,
    output logic        err_line_len,
    output logic        err_frame_lines,
    output logic        err_lval_nofval,
    output logic        err_timeout
);

    localparam int unsigned GAP_W = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_MAX     = GAP_W'(TIMEOUT_TICKS);
    localparam logic [15:0]      LINE_W16    = 16'(LINE_WIDTH);
    localparam logic [15:0]      FRAME_L16   = 16'(FRAME_LINES);

    typedef enum logic [1:0] {
        StIdle,
        StFgap,
        StLine
    } state_t;

    // FSM and measurement state
    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_pix_cnt;
    logic [15:0]        w_pix_cnt_nxt;
    logic [15:0]        r_line_cnt;
    logic [15:0]        w_line_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;
    logic [15:0]        r_run_max;
    logic [15:0]        w_run_max_nxt;
    // Set once fval has been seen low after reset, so a frame already in
    // progress when reset is released is never picked up half-way.
    logic               r_armed;

    logic               w_line_close;
    logic               w_frame_close;
    logic               w_timeout_hit;
    logic               w_nofval;

    // Output registers
    logic               r_out_fval;
    logic               r_out_lval;
    logic [15:0]        r_out_data;
    logic               r_frame_done;
    logic [15:0]        r_frame_cnt;
    logic [15:0]        r_last_line_len;
    logic [15:0]        r_last_frame_lines;
    logic [15:0]        r_last_frame_max;
    logic               r_err_line_len;
    logic               r_err_frame_lines;
    logic               r_err_lval_nofval;
    logic               r_err_timeout;

    assign w_nofval = in_lval & ~in_fval;

    // Next-state and measurement logic
    always_comb begin
        w_state_nxt    = r_state;
        w_pix_cnt_nxt  = r_pix_cnt;
        w_line_cnt_nxt = r_line_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_run_max_nxt  = r_run_max;
        w_line_close   = 1'b0;
        w_frame_close  = 1'b0;
        w_timeout_hit  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (in_fval && r_armed) begin
                    w_line_cnt_nxt = 16'd0;
                    w_gap_cnt_nxt  = '0;
                    if (in_lval) begin
                        w_state_nxt   = StLine;
                        w_pix_cnt_nxt = 16'd1;
                        w_run_max_nxt = in_data;
                    end else begin
                        w_state_nxt   = StFgap;
                        w_run_max_nxt = 16'd0;
                    end
                end
            end

            StFgap: begin
                if (!in_fval) begin
                    // Any lval here is an lval-without-fval pixel: not counted.
                    w_frame_close = 1'b1;
                    w_state_nxt   = StIdle;
                end else if (in_lval) begin
                    w_state_nxt   = StLine;
                    w_pix_cnt_nxt = 16'd1;
                    w_gap_cnt_nxt = '0;
                    if (in_data > r_run_max) begin
                        w_run_max_nxt = in_data;
                    end
                end else if (r_gap_cnt != GAP_MAX) begin
                    // Saturates, so the timeout flag fires only on the way in.
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                    w_timeout_hit = (w_gap_cnt_nxt == GAP_MAX);
                end
            end

            StLine: begin
                if (in_fval && in_lval) begin
                    if (r_pix_cnt != 16'hFFFF) begin
                        w_pix_cnt_nxt = r_pix_cnt + 16'd1;
                    end
                    if (in_data > r_run_max) begin
                        w_run_max_nxt = in_data;
                    end
                end else begin
                    w_line_close  = 1'b1;
                    w_gap_cnt_nxt = '0;
                    if (r_line_cnt != 16'hFFFF) begin
                        w_line_cnt_nxt = r_line_cnt + 16'd1;
                    end
                    if (!in_fval) begin
                        // fval dropped mid-line: line and frame close together.
                        w_frame_close = 1'b1;
                        w_state_nxt   = StIdle;
                    end else begin
                        w_state_nxt   = StFgap;
                    end
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clink_out_clk) begin
        if (rst) begin
            r_state            <= StIdle;
            r_pix_cnt          <= 16'd0;
            r_line_cnt         <= 16'd0;
            r_gap_cnt          <= '0;
            r_run_max          <= 16'd0;
            r_armed            <= 1'b0;
            r_out_fval         <= 1'b0;
            r_out_lval         <= 1'b0;
            r_out_data         <= 16'd0;
            r_frame_done       <= 1'b0;
            r_frame_cnt        <= 16'd0;
            r_last_line_len    <= 16'd0;
            r_last_frame_lines <= 16'd0;
            r_last_frame_max   <= 16'd0;
            r_err_line_len     <= 1'b0;
            r_err_frame_lines  <= 1'b0;
            r_err_lval_nofval  <= 1'b0;
            r_err_timeout      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pix_cnt  <= w_pix_cnt_nxt;
            r_line_cnt <= w_line_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_run_max  <= w_run_max_nxt;
            r_armed    <= r_armed | ~in_fval;

            r_out_fval <= in_fval;
            r_out_lval <= in_lval;
            r_out_data <= in_data;

            r_frame_done <= w_frame_close;

            if (w_line_close) begin
                r_last_line_len <= r_pix_cnt;
            end
            if (w_frame_close) begin
                // w_line_cnt_nxt already includes a line closed this cycle.
                r_last_frame_lines <= w_line_cnt_nxt;
                r_last_frame_max   <= r_run_max;
            end

            // Clear first, then count/set, so a same-cycle event survives.
            r_frame_cnt <= (stat_clr ? 16'd0 : r_frame_cnt) + {15'd0, w_frame_close};

            r_err_line_len    <= (r_err_line_len & ~stat_clr)
                               | (w_line_close & (r_pix_cnt != LINE_W16));
            r_err_frame_lines <= (r_err_frame_lines & ~stat_clr)
                               | (w_frame_close & (w_line_cnt_nxt != FRAME_L16));
            r_err_lval_nofval <= (r_err_lval_nofval & ~stat_clr) | w_nofval;
            r_err_timeout     <= (r_err_timeout & ~stat_clr) | w_timeout_hit;
        end
    end

    assign out_fval         = r_out_fval;
    assign out_lval         = r_out_lval;
    assign out_data         = r_out_data;
    assign frame_done       = r_frame_done;
    assign frame_cnt        = r_frame_cnt;
    assign last_line_len    = r_last_line_len;
    assign last_frame_lines = r_last_frame_lines;
    assign last_frame_max   = r_last_frame_max;
    assign err_line_len     = r_err_line_len;
    assign err_frame_lines  = r_err_frame_lines;
    assign err_lval_nofval  = r_err_lval_nofval;
    assign err_timeout      = r_err_timeout;

endmodule
